// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, port identifiers and grant decode.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_e;

   function automatic port_e grant_port(input logic [1:0] grant);
      return grant[1] ? PORT_D : PORT_I;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between fetch (bit 0) and data (bit 1) requests.
module rr_arbiter2
   import mem_arbiter_pkg::*;
(
   input  logic       i_req_i,
   input  logic       d_req_i,
   input  port_e      last_i,
   input  logic       upd_en_i,
   output logic [1:0] grant_o,
   output port_e      last_o
);

   always_comb begin
      grant_o = '0;
      if (i_req_i && d_req_i) begin
         grant_o = (last_i == PORT_D) ? 2'b01 : 2'b10;
      end else if (i_req_i) begin
         grant_o = 2'b01;
      end else if (d_req_i) begin
         grant_o = 2'b10;
      end

      last_o = last_i;
      if (upd_en_i && (grant_o != '0)) begin
         last_o = grant_port(grant_o);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports, one registered
// access at a time (IDLE -> ACCESS -> RESP), round-robin on contention.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned WORD_SIZE   = 16,
   parameter int unsigned MEMORY_SIZE = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 I_REQ,
   input  logic [WORD_SIZE-1:0] I_ADDR,
   output logic                 I_ACK,
   output logic [WORD_SIZE-1:0] I_RDATA,
   output logic                 I_ERR,
   input  logic                 D_REQ,
   input  logic                 D_WE,
   input  logic [WORD_SIZE-1:0] D_ADDR,
   input  logic [WORD_SIZE-1:0] D_WDATA,
   output logic                 D_ACK,
   output logic [WORD_SIZE-1:0] D_RDATA,
   output logic                 D_ERR,
   output logic                 MEM_ON,
   output logic                 MEM_W,
   output logic [WORD_SIZE-1:0] MEM_ADDR,
   output logic [WORD_SIZE-1:0] MEM_DIN,
   input  logic [WORD_SIZE-1:0] MEM_DOUT
);

   // One extra bit so a MEMORY_SIZE of 2**WORD_SIZE still compares correctly.
   localparam logic [WORD_SIZE:0] LIMIT = (WORD_SIZE + 1)'(MEMORY_SIZE);

   state_e                 state_q, state_d;
   port_e                  last_q, last_d, last_next, port_q, port_d;
   logic                   we_q, we_d;
   logic [WORD_SIZE-1:0]   addr_q, addr_d, wdata_q, wdata_d;
   logic                   i_ack_q, i_ack_d, i_err_q, i_err_d;
   logic                   d_ack_q, d_ack_d, d_err_q, d_err_d;
   logic [WORD_SIZE-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic                   mem_on_q, mem_on_d, mem_w_q, mem_w_d;
   logic [WORD_SIZE-1:0]   mem_addr_q, mem_addr_d, mem_din_q, mem_din_d;

   logic [1:0]             grant;
   logic [WORD_SIZE-1:0]   gnt_addr, rd_val;
   logic                   gnt_ok, cur_ok;

   rr_arbiter2 u_rr (
      .i_req_i  (I_REQ),
      .d_req_i  (D_REQ),
      .last_i   (last_q),
      .upd_en_i (state_q == ST_IDLE),
      .grant_o  (grant),
      .last_o   (last_next)
   );

   assign gnt_addr = grant[1] ? D_ADDR : I_ADDR;
   assign gnt_ok   = {1'b0, gnt_addr} < LIMIT;
   assign cur_ok   = {1'b0, addr_q} < LIMIT;
   assign rd_val   = (cur_ok && !we_q) ? MEM_DOUT : '0;

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      port_d     = port_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      i_ack_d    = i_ack_q;
      i_err_d    = i_err_q;
      i_rdata_d  = i_rdata_q;
      d_ack_d    = d_ack_q;
      d_err_d    = d_err_q;
      d_rdata_d  = d_rdata_q;
      mem_on_d   = mem_on_q;
      mem_w_d    = mem_w_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;

      unique case (state_q)
         ST_IDLE: begin
            if (grant != '0) begin
               state_d = ST_ACCESS;
               last_d  = last_next;
               port_d  = grant_port(grant);
               we_d    = grant[1] ? D_WE : 1'b0;
               addr_d  = gnt_addr;
               wdata_d = grant[1] ? D_WDATA : '0;
               // Memory pins are driven from registers, so they are set up at the grant edge.
               if (gnt_ok) begin
                  mem_on_d   = 1'b1;
                  mem_w_d    = we_d;
                  mem_addr_d = addr_d;
                  mem_din_d  = wdata_d;
               end else begin
                  mem_on_d = 1'b0;
                  mem_w_d  = 1'b0;
               end
            end
         end
         ST_ACCESS: begin
            state_d  = ST_RESP;
            mem_on_d = 1'b0;
            mem_w_d  = 1'b0;
            if (port_q == PORT_D) begin
               d_ack_d   = 1'b1;
               d_err_d   = !cur_ok;
               d_rdata_d = rd_val;
            end else begin
               i_ack_d   = 1'b1;
               i_err_d   = !cur_ok;
               i_rdata_d = rd_val;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            i_ack_d = 1'b0;
            d_ack_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         last_q     <= PORT_D;
         port_q     <= PORT_I;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         i_ack_q    <= 1'b0;
         i_err_q    <= 1'b0;
         i_rdata_q  <= '0;
         d_ack_q    <= 1'b0;
         d_err_q    <= 1'b0;
         d_rdata_q  <= '0;
         mem_on_q   <= 1'b0;
         mem_w_q    <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         port_q     <= port_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         i_ack_q    <= i_ack_d;
         i_err_q    <= i_err_d;
         i_rdata_q  <= i_rdata_d;
         d_ack_q    <= d_ack_d;
         d_err_q    <= d_err_d;
         d_rdata_q  <= d_rdata_d;
         mem_on_q   <= mem_on_d;
         mem_w_q    <= mem_w_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
      end
   end

   assign I_ACK    = i_ack_q;
   assign I_ERR    = i_err_q;
   assign I_RDATA  = i_rdata_q;
   assign D_ACK    = d_ack_q;
   assign D_ERR    = d_err_q;
   assign D_RDATA  = d_rdata_q;
   assign MEM_ON   = mem_on_q;
   assign MEM_W    = mem_w_q;
   assign MEM_ADDR = mem_addr_q;
   assign MEM_DIN  = mem_din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 16-word memory (word k = k+1 at start).
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        I_REQ, I_ACK, I_ERR;
   logic [15:0] I_ADDR, I_RDATA;
   logic        D_REQ, D_WE, D_ACK, D_ERR;
   logic [15:0] D_ADDR, D_WDATA, D_RDATA;
   logic        MEM_ON, MEM_W;
   logic [15:0] MEM_ADDR, MEM_DIN, MEM_DOUT;

   logic [15:0] mem [16];
   logic        mem_load;
   int          n_assert = 0;
   int          n_fail   = 0;
   int          lat;
   bit          saw_on, saw_w;

   always #5 CLK = ~CLK;

   mem_arbiter #(.WORD_SIZE(16), .MEMORY_SIZE(16)) dut (
      .CLK(CLK), .RST(RST),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA), .I_ERR(I_ERR),
      .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_ACK(D_ACK), .D_RDATA(D_RDATA), .D_ERR(D_ERR),
      .MEM_ON(MEM_ON), .MEM_W(MEM_W), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
      .MEM_DOUT(MEM_DOUT)
   );

   always @(posedge CLK) begin
      if (mem_load) begin
         for (int k = 0; k < 16; k++) mem[k] <= 16'(k + 1);
      end else if (MEM_ON && MEM_W) begin
         mem[MEM_ADDR[3:0]] <= MEM_DIN;
      end
   end

   assign MEM_DOUT = (MEM_ON && !MEM_W) ? mem[MEM_ADDR[3:0]] : 'z;

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Raise one request, wait (bounded) for its ACK, then release it; ends in the RESP cycle.
   task automatic xfer(input bit is_d, input bit we, input logic [15:0] addr,
                       input logic [15:0] wdata, output int l);
      saw_on = 1'b0;
      saw_w  = 1'b0;
      l      = 99;
      if (is_d) begin
         D_REQ = 1'b1; D_WE = we; D_ADDR = addr; D_WDATA = wdata;
      end else begin
         I_REQ = 1'b1; I_ADDR = addr;
      end
      for (int n = 1; n <= 8; n++) begin
         step();
         saw_on |= MEM_ON;
         saw_w  |= MEM_W;
         if ((is_d ? D_ACK : I_ACK) === 1'b1) begin
            l = n;
            break;
         end
      end
      I_REQ = 1'b0;
      D_REQ = 1'b0;
   endtask

   initial begin
      RST = 1'b1; mem_load = 1'b1;
      I_REQ = 1'b0; I_ADDR = '0;
      D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; D_WDATA = '0;
      @(negedge CLK);
      step();
      chk("rst_i_ack",   I_ACK,    0);
      chk("rst_d_ack",   D_ACK,    0);
      chk("rst_i_rdata", I_RDATA,  0);
      chk("rst_d_rdata", D_RDATA,  0);
      chk("rst_errs",    {I_ERR, D_ERR}, 0);
      chk("rst_mem_on",  MEM_ON,   0);
      chk("rst_mem_w",   MEM_W,    0);
      chk("rst_mem_pins", {MEM_ADDR, MEM_DIN}, 0);
      RST = 1'b0; mem_load = 1'b0;
      step();

      // Fetch only
      xfer(1'b0, 1'b0, 16'd3, 16'h0, lat);
      chk("fetch3_lat",   lat,     2);
      chk("fetch3_rdata", I_RDATA, 16'd4);
      chk("fetch3_err",   I_ERR,   0);
      chk("fetch3_d_ack", D_ACK,   0);
      chk("fetch3_on",    saw_on,  1);
      chk("fetch3_no_w",  saw_w,   0);
      step();
      chk("fetch3_ack_pulse", I_ACK,   0);
      chk("fetch3_hold",      I_RDATA, 16'd4);

      // Store then load, then fetch the stored word
      xfer(1'b1, 1'b1, 16'd5, 16'hBEEF, lat);
      chk("st5_lat",   lat,     2);
      chk("st5_w",     saw_w,   1);
      chk("st5_rdata", D_RDATA, 0);
      chk("st5_err",   D_ERR,   0);
      chk("st5_mem",   mem[5],  16'hBEEF);
      step();
      xfer(1'b1, 1'b0, 16'd5, 16'h0, lat);
      chk("ld5_lat",   lat,     2);
      chk("ld5_rdata", D_RDATA, 16'hBEEF);
      chk("ld5_no_w",  saw_w,   0);
      step();
      xfer(1'b0, 1'b0, 16'd5, 16'h0, lat);
      chk("fetch5_rdata", I_RDATA, 16'hBEEF);
      chk("d_rdata_hold", D_RDATA, 16'hBEEF);
      step();

      // Contention from reset: both held, grants alternate I, D, I, D
      RST = 1'b1;
      step();
      RST = 1'b0;
      I_REQ = 1'b1; I_ADDR = 16'd1;
      D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 16'd7;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("cont%0d_addr", k), MEM_ADDR, (k % 2 == 0) ? 16'd1 : 16'd7);
         step();
         chk($sformatf("cont%0d_i_ack", k), I_ACK, (k % 2 == 0) ? 1 : 0);
         chk($sformatf("cont%0d_d_ack", k), D_ACK, (k % 2 == 0) ? 0 : 1);
         if (k % 2 == 0) chk($sformatf("cont%0d_i_rdata", k), I_RDATA, 16'd2);
         else            chk($sformatf("cont%0d_d_rdata", k), D_RDATA, 16'd8);
         step();
      end
      I_REQ = 1'b0; D_REQ = 1'b0;
      step();

      // Out of range accesses
      xfer(1'b1, 1'b0, 16'd16, 16'h0, lat);
      chk("ld16_lat",   lat,     2);
      chk("ld16_err",   D_ERR,   1);
      chk("ld16_rdata", D_RDATA, 0);
      chk("ld16_no_on", saw_on,  0);
      step();
      chk("ld16_err_sticky", D_ERR, 1);
      xfer(1'b1, 1'b1, 16'd20, 16'hDEAD, lat);
      chk("st20_err",   D_ERR,  1);
      chk("st20_no_on", saw_on, 0);
      chk("st20_mem4",  mem[4], 16'd5);
      step();
      xfer(1'b1, 1'b0, 16'd15, 16'h0, lat);
      chk("ld15_err",   D_ERR,   0);
      chk("ld15_rdata", D_RDATA, 16'd16);
      step();
      xfer(1'b0, 1'b0, 16'hFFFF, 16'h0, lat);
      chk("fetchFFFF_err",   I_ERR,   1);
      chk("fetchFFFF_rdata", I_RDATA, 0);
      step();

      // Reset at the edge ending ACCESS of a store
      D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 16'd2; D_WDATA = 16'h1234;
      step();
      chk("rst_st_w", MEM_W, 1);
      RST = 1'b1;
      step();
      D_REQ = 1'b0; RST = 1'b0;
      chk("rst_st_mem2",  mem[2],  16'h1234);
      chk("rst_st_d_ack", D_ACK,   0);
      chk("rst_st_on_w",  {MEM_ON, MEM_W}, 0);
      chk("rst_st_rdata", {I_RDATA, D_RDATA}, 0);
      chk("rst_st_pins",  {MEM_ADDR, MEM_DIN}, 0);
      step();
      chk("rst_st_no_late_ack", D_ACK, 0);

      // Reset in RESP, then a fresh fetch
      I_REQ = 1'b1; I_ADDR = 16'd6;
      step();
      step();
      chk("rst_resp_ack_before", I_ACK, 1);
      I_REQ = 1'b0; RST = 1'b1;
      step();
      RST = 1'b0;
      chk("rst_resp_ack",   I_ACK,   0);
      chk("rst_resp_rdata", I_RDATA, 0);
      xfer(1'b0, 1'b0, 16'd6, 16'h0, lat);
      chk("post_rst_lat",   lat,     2);
      chk("post_rst_rdata", I_RDATA, 16'd7);
      chk("post_rst_err",   I_ERR,   0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
